incoming_request_queue: RTL and testbench

INCOMING_REQUEST_QUEUE -- requirements
Module: incoming_request_queue

---
 rtl/incoming_request_queue_if.sv | 22 ++
 rtl/incoming_request_queue.sv | 87 ++++++++
 tb/tb_incoming_request_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/incoming_request_queue_if.sv
// AR request bundle: valid/ready handshake plus the read-address payload.
// A transfer happens on a rising clk edge where valid and ready are both high; the sender holds valid and payload until then.
interface ar_if #(
  parameter int ID_WIDTH    = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int SIZE_WIDTH  = 3,
  parameter int BURST_WIDTH = 2,
  parameter int QOS_WIDTH   = 4
) ();
  logic                   valid;
  logic                   ready;
  logic [ID_WIDTH-1:0]    id;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [LEN_WIDTH-1:0]   len;
  logic [SIZE_WIDTH-1:0]  size;
  logic [BURST_WIDTH-1:0] burst;
  logic [QOS_WIDTH-1:0]   qos;

  modport sender   (output valid, id, addr, len, size, burst, qos, input  ready);
  modport receiver (input  valid, id, addr, len, size, burst, qos, output ready);
endinterface

// File: rtl/incoming_request_queue.sv
// FIFO for incoming AR requests with optional empty-queue cut-through,
// occupancy/peak tracking and a synchronous flush.
module incoming_request_queue #(
  parameter int ID_WIDTH     = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int BURST_WIDTH  = 2,
  parameter int QOS_WIDTH    = 4,
  parameter int DEPTH        = 8,
  parameter int BYPASS       = 0,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  ar_if.receiver                     ar_in,
  ar_if.sender                       ar_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] peak_count
);
  localparam int PW    = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + BURST_WIDTH + QOS_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q, peak_q, count_next;
  logic [PW-1:0]    in_pl, out_pl;
  logic             full, empty, bypass_hit, out_valid;
  logic             push, pop, store, mem_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign in_pl = {ar_in.id, ar_in.addr, ar_in.len, ar_in.size, ar_in.burst, ar_in.qos};

  // Readiness depends only on registered occupancy and flush, never on ar_out.ready.
  assign ar_in.ready = ~full & ~flush;
  assign bypass_hit  = (BYPASS != 0) && empty && ar_in.valid && !flush;
  assign out_valid   = !flush && (!empty || bypass_hit);
  assign ar_out.valid = out_valid;

  always_comb begin
    out_pl = '0;
    if (out_valid) out_pl = empty ? in_pl : mem[rd_ptr];
  end
  assign {ar_out.id, ar_out.addr, ar_out.len, ar_out.size, ar_out.burst, ar_out.qos} = out_pl;

  assign push = ar_in.valid & ar_in.ready;
  assign pop  = out_valid & ar_out.ready;
  // A cut-through request consumed the same cycle never touches the memory.
  assign store   = push & ~(bypass_hit & ar_out.ready);
  assign mem_pop = pop & ~empty;

  always_comb begin
    count_next = count_q;
    case ({store, mem_pop})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      peak_q  <= '0;
    end else begin
      if (store)   wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (mem_pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count_q <= count_next;
      if (count_next > peak_q) peak_q <= count_next;
    end
  end

  // Storage is left uncleared on reset; the pointers/count guarantee nothing stale is shown.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= in_pl;
  end

  assign count       = count_q;
  assign peak_count  = peak_q;
  assign almost_full = (count_q >= CNT_W'(AFULL_THRESH));
endmodule

// File: tb/tb_incoming_request_queue.sv
// Directed bench for incoming_request_queue: three instances cover DEPTH=8,
// DEPTH=5 (pointer wrap) and a BYPASS=1 configuration.
module tb_incoming_request_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ar_if a_in (), a_out ();
  ar_if b_in (), b_out ();
  ar_if c_in (), c_out ();
  logic [3:0] a_count, a_peak;
  logic [2:0] b_count, b_peak, c_count, c_peak;
  logic       a_afull, b_afull, c_afull;

  incoming_request_queue #(.DEPTH(8)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .ar_in(a_in), .ar_out(a_out),
    .count(a_count), .almost_full(a_afull), .peak_count(a_peak));
  incoming_request_queue #(.DEPTH(5)) dut_b (
    .clk(clk), .rst(rst), .flush(1'b0), .ar_in(b_in), .ar_out(b_out),
    .count(b_count), .almost_full(b_afull), .peak_count(b_peak));
  incoming_request_queue #(.DEPTH(4), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst), .flush(1'b0), .ar_in(c_in), .ar_out(c_out),
    .count(c_count), .almost_full(c_afull), .peak_count(c_peak));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {a_in.valid, a_in.id, a_in.addr, a_in.len, a_in.size, a_in.burst, a_in.qos} = '0;
    {b_in.valid, b_in.id, b_in.addr, b_in.len, b_in.size, b_in.burst, b_in.qos} = '0;
    {c_in.valid, c_in.id, c_in.addr, c_in.len, c_in.size, c_in.burst, c_in.qos} = '0;
    a_out.ready = 1'b0;
    b_out.ready = 1'b0;
    c_out.ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;

    // reset state
    check("rst_count", 64'(a_count), 0);
    check("rst_afull", 64'(a_afull), 0);
    check("rst_out_valid", 64'(a_out.valid), 0);
    check("rst_in_ready", 64'(a_in.ready), 1);

    // fill DEPTH=8 with ids 1..8, consumer stalled
    for (int i = 1; i <= 8; i++) begin
      a_in.valid = 1'b1;
      a_in.id    = 32'(i);
      a_in.addr  = 32'(i * 16);
      step();
      check("fill_count", 64'(a_count), 64'(i));
      check("fill_afull", 64'(a_afull), (i >= 6) ? 64'd1 : 64'd0);
      if (i == 1) check("first_word_id", 64'(a_out.id), 1);
    end
    a_in.id = 32'd9;
    #1;
    check("full_in_ready", 64'(a_in.ready), 0);
    step();
    check("full_stall_count", 64'(a_count), 8);
    a_in.valid = 1'b0;
    a_in.id    = '0;
    a_in.addr  = '0;

    // drain in order
    a_out.ready = 1'b1;
    #1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_valid", 64'(a_out.valid), 1);
      check("drain_id", 64'(a_out.id), 64'(i));
      check("drain_addr", 64'(a_out.addr), 64'(i * 16));
      step();
    end
    a_out.ready = 1'b0;
    #1;
    check("drained_count", 64'(a_count), 0);
    check("drained_valid", 64'(a_out.valid), 0);
    check("drained_id_zero", 64'(a_out.id), 0);
    check("drained_addr_zero", 64'(a_out.addr), 0);
    check("peak_after_fill", 64'(a_peak), 8);

    // flush with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      a_in.valid = 1'b1;
      a_in.id    = 32'(16 + i);
      step();
    end
    a_in.valid = 1'b0;
    #1;
    check("preflush_count", 64'(a_count), 3);
    check("preflush_peak", 64'(a_peak), 8);
    check("preflush_id", 64'(a_out.id), 16);
    flush = 1'b1;
    #1;
    check("flush_out_valid", 64'(a_out.valid), 0);
    check("flush_in_ready", 64'(a_in.ready), 0);
    check("flush_id_zero", 64'(a_out.id), 0);
    step();
    flush = 1'b0;
    #1;
    check("postflush_count", 64'(a_count), 0);
    check("postflush_peak", 64'(a_peak), 0);
    check("postflush_valid", 64'(a_out.valid), 0);

    // reset mid-traffic, with push and pop also requested
    for (int i = 0; i < 4; i++) begin
      a_in.valid = 1'b1;
      a_in.id    = 32'(32 + i);
      step();
    end
    check("prerst_count", 64'(a_count), 4);
    check("prerst_peak", 64'(a_peak), 4);
    a_out.ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_in.valid  = 1'b0;
    a_out.ready = 1'b0;
    #1;
    check("midrst_count", 64'(a_count), 0);
    check("midrst_valid", 64'(a_out.valid), 0);
    check("midrst_id_zero", 64'(a_out.id), 0);
    check("midrst_peak", 64'(a_peak), 0);
    check("midrst_in_ready", 64'(a_in.ready), 1);

    // DEPTH=5 streaming across the pointer wrap
    b_out.ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      b_in.valid = 1'b1;
      b_in.id    = 32'(k);
      #1;
      if (k > 1) begin
        check("wrap_valid", 64'(b_out.valid), 1);
        check("wrap_id", 64'(b_out.id), 64'(k - 1));
      end
      step();
      check("wrap_count", 64'(b_count), 1);
    end
    b_in.valid = 1'b0;
    #1;
    check("wrap_last_id", 64'(b_out.id), 12);
    step();
    check("wrap_empty_count", 64'(b_count), 0);
    b_out.ready = 1'b0;

    // BYPASS=1, consumer ready: same-cycle cut-through
    c_in.valid  = 1'b1;
    c_in.id     = 32'h2A;
    c_out.ready = 1'b1;
    #1;
    check("byp_valid", 64'(c_out.valid), 1);
    check("byp_id", 64'(c_out.id), 64'h2A);
    step();
    check("byp_count", 64'(c_count), 0);

    // BYPASS=1, consumer stalled: request is stored
    c_in.id     = 32'h3B;
    c_out.ready = 1'b0;
    #1;
    check("byp_stall_valid", 64'(c_out.valid), 1);
    check("byp_stall_id", 64'(c_out.id), 64'h3B);
    step();
    c_in.valid = 1'b0;
    c_in.id    = '0;
    #1;
    check("byp_stored_count", 64'(c_count), 1);
    check("byp_stored_id", 64'(c_out.id), 64'h3B);
    check("byp_stored_valid", 64'(c_out.valid), 1);
    c_out.ready = 1'b1;
    step();
    c_out.ready = 1'b0;
    #1;
    check("byp_final_count", 64'(c_count), 0);
    check("byp_final_valid", 64'(c_out.valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
